instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Program counter and fetch stage of the 4-bit CPU. Drives the address of the
//   combinational 16x8 program ROM and captures the returned instruction into an
//   instruction register (IR). The IR is handed to decode over a valid/ready
//   handshake. The block accepts branch redirects from execute and stops
//   fetching on HALT.
// PARAMETERS
//   ADDR_W      4        PC / ROM address width (ROM depth = 2**ADDR_W)
//   INSTR_W     8        instruction width: {opcode[7:4], operand[3:0]}
//   RESET_PC    4'd0     PC value loaded on reset
//   HALT_OP     4'b0111  opcode that stops fetching
//   CNT_W       8        width of delivered-instruction counter
// PORTS
//   clk            in   1        clock, rising edge
//   rst_n          in   1        asynchronous active-low reset
//   imem_addr      out  ADDR_W   ROM address, equals pc
//   imem_instr     in   INSTR_W  ROM data, valid in the same cycle as imem_addr
//   ir_valid       out  1        IR holds an instruction for decode
//   ir_ready       in   1        decode accepts IR this cycle
//   ir_instr       out  INSTR_W  captured instruction
//   ir_pc          out  ADDR_W   address the IR instruction was fetched from
//   branch_taken   in   1        execute redirect request (1-cycle pulse)
//   branch_target  in   ADDR_W   redirect destination
//   halted         out  1        fetch stopped on HALT
//   fetch_cnt      out  CNT_W    instructions handed to decode (saturating)
// BEHAVIOUR
//   Reset (async assert, sync to clk on release): pc=RESET_PC, state=RUN,
//     ir_valid=0, ir_instr=0, ir_pc=0, halted=0, fetch_cnt=0.
//   imem_addr = pc, combinational.
//   accept = ir_valid & ir_ready. slot_free = ~ir_valid | accept.
//   States:
//     RUN: normal fetch.
//     HALT_PEND: HALT captured, still in IR.
//     HALTED: HALT consumed, fetch idle.
//   RUN, no redirect, slot_free:
//     ir_instr<=imem_instr, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
//     If imem_instr[7:4]==HALT_OP: pc holds instead, state->HALT_PEND.
//   RUN, ~slot_free (stall): pc, IR and state hold.
//   HALT_PEND: no fetch. On accept: ir_valid<=0, state->HALTED.
//   HALTED: halted=1. pc and IR hold indefinitely; ir_ready is ignored.
//   Redirect (branch_taken=1) overrides all other actions in every state:
//     pc<=branch_target, ir_valid<=0 (flush), no capture that cycle, state->RUN,
//     halted<=0. The instruction after the redirect is fetched on the next cycle.
//     This cancels a speculatively fetched HALT.
//   An accept in the same cycle as a redirect still counts in fetch_cnt.
//   Fetch latency: an instruction appears in IR 1 cycle after pc points at it.
//     With ir_ready held high, one instruction is delivered per cycle.
//   PC arithmetic is modulo 2**ADDR_W; pc 15 -> 0, no flag.
//   fetch_cnt increments by 1 on each accept. It saturates at 2**CNT_W-1.
//   Reset asserted mid-stall or mid-HALT_PEND returns to reset values at once.
//     Any pending IR contents are lost.
// TESTING
//   1. Load ROM 0..8 (the demo program); reset; ir_ready=1 -> ir_pc=0,1,2,...
//      on consecutive cycles; HALT (0x70) at pc 8; halted=1 one cycle after
//      its accept; fetch_cnt=9.
//   2. ir_ready=0 for 3 cycles with IR=0x21 at pc 2 -> ir_instr, ir_pc and
//      imem_addr=3 stable. Release -> 0x87 from pc 3 next cycle.
//   3. branch_taken=1, target=8, while IR holds pc 6 -> ir_valid=0 next cycle.
//      The cycle after: ir_pc=8. Pc 7 is never delivered.
//   4. HALT at pc 8 in HALT_PEND, branch_taken target=2 -> halted stays 0,
//      state RUN, next IR from pc 2.
//   5. ROM all 0x00 (no HALT), ir_ready=1 -> ir_pc wraps 15->0;
//      fetch_cnt saturates at 255 after 300 cycles.
//   6. Assert rst_n=0 asynchronously mid-stall with ir_valid=1 -> all outputs
//      reset immediately. After release, fetch resumes from pc 0.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Program counter and fetch stage. Addresses a combinational
//               program ROM, captures the returned word into an instruction
//               register handed to decode over valid/ready, follows branch
//               redirects and stops fetching after a HALT is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int                ADDR_W   = 4,
  parameter int                INSTR_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'b0111,
  parameter int                CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_cnt
);

  localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] C_PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   pc_q,       pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic [INSTR_W-1:0]  ir_instr_q, ir_instr_d;
  logic [ADDR_W-1:0]   ir_pc_q,    ir_pc_d;
  logic                halted_q,   halted_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;

  logic                accept;
  logic                slot_free;
  logic                is_halt;

  assign accept    = ir_valid_q & ir_ready;
  assign slot_free = ~ir_valid_q | accept;
  assign is_halt   = (imem_instr[INSTR_W-1 -: 4] == HALT_OP);

  // Next-state logic: redirect dominates, otherwise the fetch FSM decides.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_valid_d = ir_valid_q;
    ir_instr_d = ir_instr_q;
    ir_pc_d    = ir_pc_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;

    // Delivered-instruction counter; counts an accept even during a redirect.
    if (accept && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (branch_taken) begin
      // Flush the IR and restart at the target; cancels any pending HALT.
      pc_d       = branch_target;
      ir_valid_d = 1'b0;
      state_d    = ST_RUN;
      halted_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (slot_free) begin
            ir_instr_d = imem_instr;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            if (is_halt) begin
              // Park the PC on the HALT so nothing beyond it is fetched.
              state_d = ST_HALT_PEND;
            end else begin
              pc_d = pc_q + C_PC_ONE;
            end
          end
        end
        ST_HALT_PEND: begin
          if (accept) begin
            ir_valid_d = 1'b0;
            halted_d   = 1'b1;
            state_d    = ST_HALTED;
          end
        end
        ST_HALTED: begin
          // Fetch idle until a redirect or reset.
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      ir_valid_q <= 1'b0;
      ir_instr_q <= '0;
      ir_pc_q    <= '0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
      ir_instr_q <= ir_instr_d;
      ir_pc_q    <= ir_pc_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign ir_valid  = ir_valid_q;
  assign ir_instr  = ir_instr_q;
  assign ir_pc     = ir_pc_q;
  assign halted    = halted_q;
  assign fetch_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. A behavioural ROM
//               feeds the DUT; expected {pc, instr} deliveries are queued as
//               stimulus is applied and compared when decode accepts the IR.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               ir_valid;
  logic               ir_ready = 1'b0;
  logic [INSTR_W-1:0] ir_instr;
  logic [ADDR_W-1:0]  ir_pc;
  logic               branch_taken = 1'b0;
  logic [ADDR_W-1:0]  branch_target = '0;
  logic               halted;
  logic [CNT_W-1:0]   fetch_cnt;

  logic [INSTR_W-1:0] rom [16];
  logic [11:0]        exp_q [$];

  int n_checks = 0;
  int n_fails  = 0;

  instruction_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_instr      (ir_instr),
    .ir_pc         (ir_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halted        (halted),
    .fetch_cnt     (fetch_cnt)
  );

  assign imem_instr = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted IR must match the next queued delivery.
  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_delivery", exp_q.size(), 1);
      end else begin
        check_eq("deliver", {20'd0, ir_pc, ir_instr}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_seq(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-1:0] p;
      p = ADDR_W'((start + i) % 16);
      exp_q.push_back({p, rom[p]});
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic wait_ir_pc(input logic [ADDR_W-1:0] p, input int max_cycles);
    for (int i = 0; i < max_cycles && !(ir_valid && ir_pc == p); i++) begin
      @(posedge clk); #1;
    end
    check_eq("reach_pc", {31'd0, ir_valid}, 1);
    check_eq("reach_pc_val", ir_pc, p);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_demo();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h10; rom[1] = 8'h35; rom[2] = 8'h21; rom[3] = 8'h87;
    rom[4] = 8'h42; rom[5] = 8'h53; rom[6] = 8'h64; rom[7] = 8'h95;
    rom[8] = 8'h70;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- 1: reset values, straight-line run to HALT
    load_demo();
    ir_ready = 1'b1;
    #12;
    check_eq("rst_addr",   imem_addr, 0);
    check_eq("rst_valid",  ir_valid, 0);
    check_eq("rst_instr",  ir_instr, 0);
    check_eq("rst_pc",     ir_pc, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_cnt",    fetch_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_seq(0, 9);
    wait_drain(20);
    check_eq("t1_halted", halted, 1);
    check_eq("t1_valid",  ir_valid, 0);
    check_eq("t1_cnt",    fetch_cnt, 9);
    check_eq("t1_addr",   imem_addr, 8);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t1_halted_hold", halted, 1);
    check_eq("t1_addr_hold",   imem_addr, 8);

    // ---- 2: stall with 0x21 from pc 2 in IR
    do_reset();
    ir_ready = 1'b1;
    push_seq(0, 2);
    wait_ir_pc(4'd2, 10);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("t2_stall_instr", ir_instr, 8'h21);
      check_eq("t2_stall_pc",    ir_pc, 2);
      check_eq("t2_stall_addr",  imem_addr, 3);
      check_eq("t2_stall_valid", ir_valid, 1);
    end
    push_seq(2, 5);
    ir_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t2_rel_pc",    ir_pc, 3);
    check_eq("t2_rel_instr", ir_instr, 8'h87);

    // ---- 3: redirect to 8 while IR holds pc 6 (accepted that same cycle)
    wait_ir_pc(4'd6, 10);
    branch_taken  = 1'b1;
    branch_target = 4'd8;
    @(posedge clk); #1;
    check_eq("t3_flush_valid", ir_valid, 0);
    check_eq("t3_flush_addr",  imem_addr, 8);
    branch_taken = 1'b0;
    ir_ready     = 1'b0;
    @(posedge clk); #1;
    check_eq("t3_tgt_pc",    ir_pc, 8);
    check_eq("t3_tgt_instr", ir_instr, 8'h70);
    check_eq("t3_tgt_valid", ir_valid, 1);

    // ---- 4: redirect out of HALT_PEND cancels the HALT
    @(posedge clk); #1;
    check_eq("t4_pend_valid",  ir_valid, 1);
    check_eq("t4_pend_addr",   imem_addr, 8);
    check_eq("t4_pend_halted", halted, 0);
    branch_taken  = 1'b1;
    branch_target = 4'd2;
    @(posedge clk); #1;
    check_eq("t4_flush_valid",  ir_valid, 0);
    check_eq("t4_flush_halted", halted, 0);
    check_eq("t4_flush_addr",   imem_addr, 2);
    branch_taken = 1'b0;
    push_seq(2, 7);
    ir_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t4_resume_pc", ir_pc, 2);
    wait_drain(20);
    check_eq("t4_halted", halted, 1);
    check_eq("t4_cnt",    fetch_cnt, 14);

    // ---- 6: asynchronous reset mid-stall
    ir_ready = 1'b0;
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("t6_stall_valid", ir_valid, 1);
    check_eq("t6_stall_addr",  imem_addr, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_valid", ir_valid, 0);
    check_eq("t6_async_addr",  imem_addr, 0);
    check_eq("t6_async_instr", ir_instr, 0);
    check_eq("t6_async_pc",    ir_pc, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_seq(0, 9);
    ir_ready = 1'b1;
    wait_drain(20);
    check_eq("t6_halted", halted, 1);
    check_eq("t6_cnt",    fetch_cnt, 9);

    // ---- 5: no HALT, pc wraps, counter saturates
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    ir_ready = 1'b1;
    do_reset();
    push_seq(0, 300);
    wait_drain(320);
    ir_ready = 1'b0;
    check_eq("t5_cnt_sat",  fetch_cnt, 255);
    check_eq("t5_wrap_pc",  ir_pc, 12);
    check_eq("t5_wrap_addr", imem_addr, 13);
    check_eq("t5_halted",   halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
